// File: rtl/tournament_select_pkg.sv
// Shared constants, FSM state type and LFSR step function for the tournament
// selection stage and its neighbours.
package tournament_select_pkg;

    localparam int POP_SIZE        = 50;
    localparam int IDX_WIDTH       = 8;
    localparam int SELF_FIT_LENGTH = 10;
    localparam int CAND_WIDTH      = 6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as state bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [IDX_WIDTH-1:0]  POP_IDX  = IDX_WIDTH'(POP_SIZE);
    localparam logic [CAND_WIDTH-1:0] POP_CAND = CAND_WIDTH'(POP_SIZE);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        IDLE    = 3'd1,
        PICK_A  = 3'd2,
        PICK_B  = 3'd3,
        COMPARE = 3'd4,
        OUT     = 3'd5
    } sel_state_t;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        lfsr16_next = {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tournament_select_lfsr16.sv
// 16-bit Fibonacci LFSR that steps once per enabled cycle; also used by the
// mutation stage for its own random draws.
module lfsr16
    import tournament_select_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] r_state;

    // Shift register; a zero seed would lock the sequence, so SEED must be non-zero.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (en_i) begin
            r_state <= lfsr16_next(r_state);
        end
    end

    assign state_o = r_state;

endmodule

// File: rtl/tournament_select.sv
// Collects per-individual energies, tracks the generation minimum and serves
// binary-tournament parent selections once the population is complete.
module tournament_select
    import tournament_select_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  logic [IDX_WIDTH-1:0]       ind_idx_i,
    input  logic [SELF_FIT_LENGTH-1:0] total_energy_i,
    input  logic                       new_gen_i,
    input  logic                       sel_req_i,
    output logic                       ready_ff_o,
    output logic                       sel_busy_ff_o,
    output logic                       sel_valid_ff_o,
    output logic [IDX_WIDTH-1:0]       sel_idx_ff_o,
    output logic [SELF_FIT_LENGTH-1:0] sel_energy_ff_o,
    output logic [IDX_WIDTH-1:0]       best_idx_ff_o,
    output logic [SELF_FIT_LENGTH-1:0] best_energy_ff_o,
    output logic [IDX_WIDTH-1:0]       wr_count_ff_o
);

    sel_state_t                 r_state;
    logic [SELF_FIT_LENGTH-1:0] r_mem [POP_SIZE];
    logic [CAND_WIDTH-1:0]      r_cand_a;
    logic [CAND_WIDTH-1:0]      r_cand_b;
    logic                       r_ready;
    logic                       r_busy;
    logic                       r_sel_valid;
    logic [IDX_WIDTH-1:0]       r_sel_idx;
    logic [SELF_FIT_LENGTH-1:0] r_sel_energy;
    logic [IDX_WIDTH-1:0]       r_best_idx;
    logic [SELF_FIT_LENGTH-1:0] r_best_energy;
    logic [IDX_WIDTH-1:0]       r_wr_count;

    logic [15:0]                w_lfsr;
    logic [CAND_WIDTH-1:0]      w_cand;
    logic [CAND_WIDTH-1:0]      w_wr_slot;
    logic                       w_cand_ok;
    logic                       w_wr_accept;
    logic                       w_lfsr_en;
    logic                       w_unused_lfsr;
    logic [SELF_FIT_LENGTH-1:0] w_energy_a;
    logic [SELF_FIT_LENGTH-1:0] w_energy_b;

    assign w_wr_accept   = in_valid_i && !new_gen_i && (ind_idx_i < POP_IDX);
    assign w_wr_slot     = ind_idx_i[CAND_WIDTH-1:0];
    assign w_lfsr_en     = (r_state == PICK_A) || (r_state == PICK_B);
    assign w_cand        = w_lfsr[CAND_WIDTH-1:0];
    assign w_cand_ok     = (w_cand < POP_CAND);
    assign w_unused_lfsr = ^w_lfsr[15:CAND_WIDTH];

    lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .en_i    (w_lfsr_en),
        .state_o (w_lfsr)
    );

    // A write landing on a candidate in the COMPARE cycle is forwarded so the
    // tournament sees the freshest energy.
    assign w_energy_a = (w_wr_accept && (w_wr_slot == r_cand_a)) ? total_energy_i : r_mem[r_cand_a];
    assign w_energy_b = (w_wr_accept && (w_wr_slot == r_cand_b)) ? total_energy_i : r_mem[r_cand_b];

    // Fitness register file.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POP_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_mem[w_wr_slot] <= total_energy_i;
        end
    end

    // Collection count, best tracker and tournament sequencing.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= COLLECT;
            r_cand_a      <= '0;
            r_cand_b      <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_sel_valid   <= 1'b0;
            r_sel_idx     <= '0;
            r_sel_energy  <= '0;
            r_best_idx    <= '0;
            r_best_energy <= '1;
            r_wr_count    <= '0;
        end else if (new_gen_i) begin
            r_state       <= COLLECT;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_sel_valid   <= 1'b0;
            r_best_idx    <= '0;
            r_best_energy <= '1;
            r_wr_count    <= '0;
        end else begin
            r_sel_valid <= 1'b0;
            // Strict compare keeps the earlier index on ties.
            if (w_wr_accept && (total_energy_i < r_best_energy)) begin
                r_best_idx    <= ind_idx_i;
                r_best_energy <= total_energy_i;
            end
            case (r_state)
                COLLECT: begin
                    if (w_wr_accept) begin
                        r_wr_count <= r_wr_count + IDX_WIDTH'(1);
                        if (r_wr_count == (POP_IDX - IDX_WIDTH'(1))) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (sel_req_i) begin
                        r_state <= PICK_A;
                        r_busy  <= 1'b1;
                    end
                end
                PICK_A: begin
                    if (w_cand_ok) begin
                        r_cand_a <= w_cand;
                        r_state  <= PICK_B;
                    end
                end
                PICK_B: begin
                    if (w_cand_ok) begin
                        r_cand_b <= w_cand;
                        r_state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_energy_b < w_energy_a) begin
                        r_sel_idx    <= IDX_WIDTH'(r_cand_b);
                        r_sel_energy <= w_energy_b;
                    end else begin
                        r_sel_idx    <= IDX_WIDTH'(r_cand_a);
                        r_sel_energy <= w_energy_a;
                    end
                    r_state <= OUT;
                end
                OUT: begin
                    r_sel_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= COLLECT;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready_ff_o       = r_ready;
    assign sel_busy_ff_o    = r_busy;
    assign sel_valid_ff_o   = r_sel_valid;
    assign sel_idx_ff_o     = r_sel_idx;
    assign sel_energy_ff_o  = r_sel_energy;
    assign best_idx_ff_o    = r_best_idx;
    assign best_energy_ff_o = r_best_energy;
    assign wr_count_ff_o    = r_wr_count;

endmodule

// File: tb/tb_tournament_select.sv
// Self-checking bench for tournament_select: transaction-level reference model
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_tournament_select;

    localparam int NPOP = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] ind_idx = 8'd0;
    logic [9:0] energy = 10'd0;
    logic       new_gen = 1'b0;
    logic       sel_req = 1'b0;
    logic       ready_ff_o, sel_busy_ff_o, sel_valid_ff_o;
    logic [7:0] sel_idx_ff_o, best_idx_ff_o, wr_count_ff_o;
    logic [9:0] sel_energy_ff_o, best_energy_ff_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    tournament_select dut (
        .clk_i            (clk),
        .rst_n            (rst_n),
        .in_valid_i       (in_valid),
        .ind_idx_i        (ind_idx),
        .total_energy_i   (energy),
        .new_gen_i        (new_gen),
        .sel_req_i        (sel_req),
        .ready_ff_o       (ready_ff_o),
        .sel_busy_ff_o    (sel_busy_ff_o),
        .sel_valid_ff_o   (sel_valid_ff_o),
        .sel_idx_ff_o     (sel_idx_ff_o),
        .sel_energy_ff_o  (sel_energy_ff_o),
        .best_idx_ff_o    (best_idx_ff_o),
        .best_energy_ff_o (best_energy_ff_o),
        .wr_count_ff_o    (wr_count_ff_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole tournaments are planned when a request is taken.
    int m_mem [NPOP];
    int m_best_e, m_best_i, m_count, m_ready, m_busy, m_valid, m_sel_i, m_sel_e;
    int m_edge, m_t0, m_P, m_ra, m_ca, m_cb, m_done, m_lfsr;
    int m_seq [0:127];
    bit m_collecting, m_in_tour;

    function automatic int ref_next(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 'hFFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NPOP; i++) m_mem[i] = 0;
        m_best_e = 1023; m_best_i = 0; m_count = 0; m_ready = 0; m_busy = 0;
        m_valid = 0; m_sel_i = 0; m_sel_e = 0; m_collecting = 1'b1; m_in_tour = 1'b0;
        m_lfsr = 'hACE1;
    endtask

    task automatic model_start();
        int k;
        m_seq[0] = m_lfsr; k = 0; m_ra = 0;
        while (((m_seq[k] & 63) >= NPOP) && (k < 100)) begin
            m_seq[k+1] = ref_next(m_seq[k]); k++; m_ra++;
        end
        m_ca = m_seq[k] & 63;
        m_seq[k+1] = ref_next(m_seq[k]); k++;
        while (((m_seq[k] & 63) >= NPOP) && (k < 120)) begin
            m_seq[k+1] = ref_next(m_seq[k]); k++;
        end
        m_cb = m_seq[k] & 63;
        m_P = k + 1;
        m_seq[m_P] = ref_next(m_seq[k]);
        m_t0 = m_edge; m_in_tour = 1'b1; m_busy = 1;
    endtask

    task automatic model_step();
        bit idle_now;
        int steps, ii, ee;
        m_edge++;
        idle_now = !m_collecting && !m_in_tour;
        ii = int'(ind_idx);
        ee = int'(energy);
        if (new_gen) begin
            if (m_in_tour) begin
                steps = m_edge - m_t0;
                if (steps > m_P) steps = m_P;
                m_lfsr = m_seq[steps];
            end
            m_in_tour = 1'b0; m_busy = 0; m_valid = 0; m_count = 0; m_ready = 0;
            m_best_e = 1023; m_best_i = 0; m_collecting = 1'b1;
        end else begin
            m_valid = 0;
            if (in_valid && (ii < NPOP)) begin
                m_mem[ii] = ee;
                if (ee < m_best_e) begin m_best_e = ee; m_best_i = ii; end
                if (m_collecting) begin
                    m_count++;
                    if (m_count == NPOP) begin m_collecting = 1'b0; m_ready = 1; end
                end
            end
            if (m_in_tour) begin
                if (m_edge == m_t0 + m_P + 1) begin
                    if (m_mem[m_cb] < m_mem[m_ca]) begin m_sel_i = m_cb; m_sel_e = m_mem[m_cb]; end
                    else begin m_sel_i = m_ca; m_sel_e = m_mem[m_ca]; end
                end else if (m_edge == m_t0 + m_P + 2) begin
                    m_valid = 1; m_busy = 0; m_in_tour = 1'b0; m_lfsr = m_seq[m_P]; m_done++;
                end
            end else if (idle_now && sel_req) begin
                model_start();
            end
        end
    endtask

    initial begin
        m_edge = 0; m_done = 0; m_P = 2; m_ra = 0; m_ca = 0; m_cb = 0; m_t0 = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ready",       32'(ready_ff_o),       32'(m_ready));
                chk("busy",        32'(sel_busy_ff_o),    32'(m_busy));
                chk("sel_valid",   32'(sel_valid_ff_o),   32'(m_valid));
                chk("sel_idx",     32'(sel_idx_ff_o),     32'(m_sel_i));
                chk("sel_energy",  32'(sel_energy_ff_o),  32'(m_sel_e));
                chk("best_idx",    32'(best_idx_ff_o),    32'(m_best_i));
                chk("best_energy", 32'(best_energy_ff_o), 32'(m_best_e));
                chk("wr_count",    32'(wr_count_ff_o),    32'(m_count));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic put(input int idx, input int e);
        @(negedge clk);
        in_valid = 1'b1; ind_idx = 8'(idx); energy = 10'(e);
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_gen();
        @(negedge clk); new_gen = 1'b1;
        @(negedge clk); new_gen = 1'b0;
    endtask

    task automatic populate(input int mode);
        for (int i = 0; i < NPOP; i++) put(i, (mode == 0) ? 100 : i * 10);
        drop();
    endtask

    task automatic request(output int lat);
        bit seen;
        seen = 1'b0; lat = 0;
        @(negedge clk); sel_req = 1'b1;
        @(negedge clk); sel_req = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (sel_valid_ff_o === 1'b1) begin lat = i; seen = 1'b1; break; end
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL sel_valid_timeout: got no winner, required one within 60 cycles");
        end
    endtask

    initial begin
        int lat, nv, base;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_best_energy", 32'(best_energy_ff_o), 32'd1023);
        chk("rst_ready",       32'(ready_ff_o),       32'd0);
        chk("rst_count",       32'(wr_count_ff_o),    32'd0);
        chk("rst_sel_idx",     32'(sel_idx_ff_o),     32'd0);

        put(60, 1); drop();
        chk("oor_count", 32'(wr_count_ff_o),    32'd0);
        chk("oor_best",  32'(best_energy_ff_o), 32'd1023);

        for (int i = 0; i < NPOP; i++) begin
            put(i, (i == 7) ? 3 : 500);
            if (i == NPOP - 1) chk("ready_before_last_edge", 32'(ready_ff_o), 32'd0);
        end
        drop();
        chk("pop_ready",    32'(ready_ff_o),       32'd1);
        chk("pop_count",    32'(wr_count_ff_o),    32'd50);
        chk("pop_best_idx", 32'(best_idx_ff_o),    32'd7);
        chk("pop_best_e",   32'(best_energy_ff_o), 32'd3);

        // Seed 0xACE1 draws 33 then 3; equal energies go to cand_a.
        request(lat);
        chk("first_lat",    32'(lat),             32'd4);
        chk("first_idx",    32'(sel_idx_ff_o),    32'd33);
        chk("first_energy", 32'(sel_energy_ff_o), 32'd500);
        chk("model_ca",     32'(m_ca),            32'd33);
        chk("model_cb",     32'(m_cb),            32'd3);
        @(negedge clk);
        chk("valid_one_cycle", 32'(sel_valid_ff_o), 32'd0);

        pulse_gen();
        populate(0);
        chk("flat_best_idx", 32'(best_idx_ff_o), 32'd0);
        chk("flat_best_e",   32'(best_energy_ff_o), 32'd100);
        for (int r = 0; r < 20; r++) begin
            request(lat);
            chk("flat_lat",    32'(lat),          32'(m_P + 2));
            chk("flat_idx_a",  32'(sel_idx_ff_o), 32'(m_ca));
        end

        pulse_gen();
        populate(1);
        chk("ramp_best_e", 32'(best_energy_ff_o), 32'd0);
        for (int r = 0; r < 20; r++) begin
            request(lat);
            chk("ramp_lat", 32'(lat), 32'(m_P + 2));
            chk("ramp_idx_min", 32'(sel_idx_ff_o), 32'((m_ca < m_cb) ? m_ca : m_cb));
            chk("ramp_energy", 32'(sel_energy_ff_o), 32'(int'(sel_idx_ff_o) * 10));
        end

        base = m_done; nv = 0;
        @(negedge clk); sel_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sel_valid_ff_o === 1'b1) nv++;
        end
        sel_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sel_valid_ff_o === 1'b1) nv++;
        end
        chk("cont_winners", 32'(nv), 32'(m_done - base));
        chk("cont_enough",  32'(nv >= 10), 32'd1);

        // Abort a tournament from inside PICK_B.
        @(negedge clk); sel_req = 1'b1;
        @(negedge clk); sel_req = 1'b0;
        repeat (m_ra + 1) @(negedge clk);
        new_gen = 1'b1;
        @(negedge clk); new_gen = 1'b0;
        chk("abort_count", 32'(wr_count_ff_o),    32'd0);
        chk("abort_ready", 32'(ready_ff_o),       32'd0);
        chk("abort_best",  32'(best_energy_ff_o), 32'd1023);
        chk("abort_busy",  32'(sel_busy_ff_o),    32'd0);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sel_valid_ff_o === 1'b1) nv++;
        end
        chk("abort_no_valid", 32'(nv), 32'd0);

        // Asynchronous reset while the tournament sits in COMPARE.
        populate(1);
        @(negedge clk); sel_req = 1'b1;
        @(negedge clk); sel_req = 1'b0;
        repeat (m_P) @(negedge clk);
        chk("cmp_busy", 32'(sel_busy_ff_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready",  32'(ready_ff_o),       32'd0);
        chk("arst_busy",   32'(sel_busy_ff_o),    32'd0);
        chk("arst_valid",  32'(sel_valid_ff_o),   32'd0);
        chk("arst_idx",    32'(sel_idx_ff_o),     32'd0);
        chk("arst_energy", 32'(sel_energy_ff_o),  32'd0);
        chk("arst_best_i", 32'(best_idx_ff_o),    32'd0);
        chk("arst_best_e", 32'(best_energy_ff_o), 32'd1023);
        chk("arst_count",  32'(wr_count_ff_o),    32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // LFSR restarts from the seed: candidates 33 and 3, energy 10*idx.
        populate(1);
        request(lat);
        chk("reseed_lat",    32'(lat),             32'd4);
        chk("reseed_idx",    32'(sel_idx_ff_o),    32'd3);
        chk("reseed_energy", 32'(sel_energy_ff_o), 32'd30);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
